uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller downstream of the UART receiver. Consumes 8N1 bytes (rx_byte / rx_complete
//  1-cycle strobe) and parses frames: SOF, LEN, LEN payload bytes, XOR checksum. Buffers the
//  payload and holds a valid frame for the consumer (CPU I/O port / loader) until acknowledged.
//  Reports length, checksum, overrun and inter-byte-timeout errors.
// PARAMETERS
//  MAX_LEN         16          max payload bytes per frame (1..255)
//  SOF_BYTE        8'hA5       start-of-frame marker
//  TIMEOUT_CYCLES  100000      sourceClk cycles allowed between bytes inside a frame
//  LEN_W           $clog2(MAX_LEN+1)   derived; width of length/index fields
// PORTS
//  sourceClk    in   1      clock
//  reset        in   1      synchronous, active-low
//  rx_byte      in   8      byte from receiver; valid only when rx_complete=1
//  rx_complete  in   1      1-cycle strobe, one per received byte
//  frame_valid  out  1      complete good frame held in buffer
//  frame_len    out  LEN_W  payload length of held frame (stable while frame_valid)
//  rd_addr      in   LEN_W  payload read index (0..frame_len-1)
//  rd_data      out  8      buf[rd_addr], combinational read
//  frame_ack    in   1      consumer releases held frame (honoured only while frame_valid)
//  err_len      out  1      1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  err_csum     out  1      1-cycle pulse: checksum mismatch
//  err_overrun  out  1      1-cycle pulse: byte arrived while frame held, byte dropped
//  err_timeout  out  1      1-cycle pulse: inter-byte gap reached TIMEOUT_CYCLES
//  err_count    out  8      total errors, saturates at 8'hFF
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=FrIdle; frame_valid, frame_len, all err_* and err_count=0;
//    idx, csum, gap counter=0. Buffer contents undefined. Reset mid-frame discards the frame.
//  - FrIdle: rx_complete & rx_byte==SOF_BYTE -> FrLen; any other byte silently dropped.
//  - FrLen: on byte: 0 or >MAX_LEN -> err_len, FrIdle. Else len<=byte, csum<=byte, idx<=0 -> FrPayload.
//  - FrPayload: on byte: buf[idx]<=byte, csum<=csum^byte, idx<=idx+1; byte with idx==len-1 -> FrCheck.
//  - FrCheck: on byte: byte==csum -> FrHold, frame_valid=1 next cycle (1-cycle latency after
//    checksum strobe); else err_csum, FrIdle. Checksum = XOR of LEN and all payload bytes.
//  - FrHold: frame_valid=1, frame_len=len. frame_ack -> FrIdle, frame_valid=0 next cycle.
//    rx_complete without ack -> err_overrun, byte dropped, stay FrHold.
//    rx_complete and frame_ack same cycle -> ack wins; byte evaluated as in FrIdle (SOF starts new frame).
//  - frame_ack outside FrHold ignored. rd_addr>=frame_len returns stale buffer data (no error).
//  - Timeout: gap counter cleared on every rx_complete and in FrIdle/FrHold; increments in
//    FrLen/FrPayload/FrCheck; at TIMEOUT_CYCLES -> err_timeout, FrIdle. Strobe on same cycle wins.
//  - err_* are registered, high exactly 1 cycle; each pulse increments err_count (sat at 255).
//  - Buffer writes only in FrPayload; held frame never overwritten while frame_valid=1.
// STRUCTURE
//  - Shared package (uart_pkg): typedef enum FrameState {FrIdle,FrLen,FrPayload,FrCheck,FrHold};
//    SOF_BYTE default constant.
//  - Sub-module rx_frame_buf: MAX_LEN x 8 register array, 1 sync write port, 1 async read port.
//  - Timeout counter width $clog2(TIMEOUT_CYCLES+1); single always_ff FSM + datapath.
// TESTING (MAX_LEN=16, TIMEOUT_CYCLES=1000)
//  1. Bytes A5 03 11 22 33 03^11^22^33=03 -> frame_valid=1 one cycle after last strobe,
//     frame_len=3, rd_addr 0/1/2 -> 11/22/33; frame_ack -> frame_valid=0 next cycle.
//  2. A5 00 and A5 11 (LEN=17) -> err_len pulse each, state FrIdle, err_count=2.
//  3. A5 02 AA BB 00 (expected 02^AA^BB=13) -> err_csum pulse, frame_valid stays 0.
//  4. Hold good frame, send 55 -> err_overrun, buffer unchanged; then frame_ack with A5 strobe
//     same cycle -> frame_valid=0, new frame started (FrLen).
//  5. A5 04 01 then 1000-cycle gap -> err_timeout pulse, FrIdle; next A5 01 7E 7F accepted.
//  6. Reset asserted mid-payload -> all outputs 0 next cycle; garbage bytes then ignored until SOF.

Source files
------------

// File: rtl/uart_pkg.sv
// +-----------------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART receive-side frame path  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        FrIdle    = 3'd0,
        FrLen     = 3'd1,
        FrPayload = 3'd2,
        FrCheck   = 3'd3,
        FrHold    = 3'd4
    } FrameState;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // Saturating increment used by the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_frame_buf.sv
// +-----------------------------------------------------------------------------+
// | rx_frame_buf : payload store, one synchronous write port, one async read    |
// | Revision     : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rx_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          sourceClk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [7:0] mem_q [DEPTH];

    // Contents are intentionally not reset; the controller never exposes them
    // until a complete frame has been written.
    always_ff @(posedge sourceClk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Addresses past the physical depth read as zero rather than aliasing.
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr <= LAST_ADDR) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
// +-----------------------------------------------------------------------------+
// | uart_rx_frame_ctrl : parses SOF/LEN/payload/XOR-checksum frames from a UART |
// |                      receiver and holds good frames until acknowledged      |
// | Revision           : 1.0 - initial release                                  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         LEN_W          = $clog2(MAX_LEN + 1)
) (
    input  logic             sourceClk,
    input  logic             reset,
    input  logic [7:0]       rx_byte,
    input  logic             rx_complete,
    output logic             frame_valid,
    output logic [LEN_W-1:0] frame_len,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    input  logic             frame_ack,
    output logic             err_len,
    output logic             err_csum,
    output logic             err_overrun,
    output logic             err_timeout,
    output logic [7:0]       err_count
);

    localparam int               TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    FrameState        state_q,       state_d;
    logic [LEN_W-1:0] len_q,         len_d;
    logic [LEN_W-1:0] idx_q,         idx_d;
    logic [7:0]       csum_q,        csum_d;
    logic [TMO_W-1:0] gap_q,         gap_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_len_q,     err_len_d;
    logic             err_csum_q,    err_csum_d;
    logic             err_overrun_q, err_overrun_d;
    logic             err_timeout_q, err_timeout_d;
    logic [7:0]       err_count_q,   err_count_d;

    logic             buf_we;
    logic             in_frame;
    logic             is_sof;

    rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (LEN_W)
    ) u_buf (
        .sourceClk (sourceClk),
        .wr_en     (buf_we),
        .wr_addr   (idx_q),
        .wr_data   (rx_byte),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    assign in_frame = (state_q == FrLen) || (state_q == FrPayload) || (state_q == FrCheck);
    assign is_sof   = rx_complete && (rx_byte == SOF_BYTE);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        csum_d        = csum_q;
        gap_d         = '0;
        frame_valid_d = frame_valid_q;
        err_len_d     = 1'b0;
        err_csum_d    = 1'b0;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;
        buf_we        = 1'b0;

        // Gap counter only runs mid-frame; a strobe always restarts it.
        if (in_frame && !rx_complete) begin
            if (gap_q == TIMEOUT_LAST) begin
                err_timeout_d = 1'b1;
                state_d       = FrIdle;
            end else begin
                gap_d = gap_q + TMO_W'(1);
            end
        end

        case (state_q)
            FrIdle: begin
                if (is_sof) begin
                    state_d = FrLen;
                end
            end
            FrLen: begin
                if (rx_complete) begin
                    if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = FrIdle;
                    end else begin
                        len_d   = rx_byte[LEN_W-1:0];
                        csum_d  = rx_byte;
                        idx_d   = '0;
                        state_d = FrPayload;
                    end
                end
            end
            FrPayload: begin
                if (rx_complete) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + LEN_W'(1);
                    if ((idx_q + LEN_W'(1)) == len_q) begin
                        state_d = FrCheck;
                    end
                end
            end
            FrCheck: begin
                if (rx_complete) begin
                    if (rx_byte == csum_q) begin
                        state_d       = FrHold;
                        frame_valid_d = 1'b1;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = FrIdle;
                    end
                end
            end
            FrHold: begin
                // Ack wins over a coincident byte, which is then parsed as if idle.
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = is_sof ? FrLen : FrIdle;
                end else if (rx_complete) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: begin
                state_d       = FrIdle;
                frame_valid_d = 1'b0;
            end
        endcase

        err_count_d = err_count_q;
        if (err_len_d || err_csum_d || err_overrun_d || err_timeout_d) begin
            err_count_d = sat_inc8(err_count_q);
        end
    end

    always_ff @(posedge sourceClk) begin
        if (!reset) begin
            state_q       <= FrIdle;
            len_q         <= '0;
            idx_q         <= '0;
            csum_q        <= 8'h00;
            gap_q         <= '0;
            frame_valid_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_csum_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            csum_q        <= csum_d;
            gap_q         <= gap_d;
            frame_valid_q <= frame_valid_d;
            err_len_q     <= err_len_d;
            err_csum_q    <= err_csum_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_len   = len_q;
    assign err_len     = err_len_q;
    assign err_csum    = err_csum_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;
    assign err_count   = err_count_q;

endmodule

`default_nettype wire
